de2_115_qsys_cpu_ocimem_arbiter: RTL and testbench

DE2_115_QSYS_CPU_OCIMEM_ARBITER -- requirements
Module: DE2_115_QSYS_cpu_ocimem_arbiter

---
 rtl/de2_115_qsys_cpu_ocimem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_de2_115_qsys_cpu_ocimem_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/de2_115_qsys_cpu_ocimem_arbiter.sv
// rtl/de2_115_qsys_cpu_ocimem_arbiter.sv - OCI RAM arbiter between CPU slave port and JTAG debug strobes

module de2_115_qsys_cpu_ocimem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    input  logic [7:0]  av_address,
    input  logic        av_read,
    input  logic        av_write,
    input  logic        av_debugaccess,
    input  logic [31:0] av_writedata,
    input  logic [3:0]  av_byteenable,
    output logic [31:0] av_readdata,
    output logic        av_waitrequest,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_be,
    output logic        ram_we,
    input  logic [31:0] ram_rdata,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CPU_ACC  = 3'd1,
        S_CPU_RD   = 3'd2,
        S_CPU_DONE = 3'd3,
        S_JTG_ACC  = 3'd4,
        S_JTG_RD   = 3'd5
    } state_t;

    // last_grant encoding: 0 = CPU was granted last, 1 = JTAG was granted last
    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_JTAG = 1'b1;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;
    logic [7:0]  jtag_addr_q, jtag_addr_d;
    logic [31:0] jtag_wdata_q, jtag_wdata_d;
    logic        last_grant_q, last_grant_d;
    logic        cpu_wr_q, cpu_wr_d;
    logic [31:0] mon_d_reg_q, mon_d_reg_d;
    logic [31:0] av_readdata_q, av_readdata_d;
    logic        monitor_ready_q, monitor_ready_d;
    logic        monitor_error_q, monitor_error_d;

    logic        cpu_req;
    logic        any_strobe;
    logic        unused_jdo;

    assign cpu_req    = av_read | av_write;
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign av_readdata   = av_readdata_q;
    assign MonDReg       = mon_d_reg_q;
    assign monitor_ready = monitor_ready_q;
    assign monitor_error = monitor_error_q;

    // State and captured-request registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            pend_q          <= 1'b0;
            pend_wr_q       <= 1'b0;
            jtag_addr_q     <= 8'h00;
            jtag_wdata_q    <= 32'h0;
            last_grant_q    <= GRANT_CPU;
            cpu_wr_q        <= 1'b0;
            mon_d_reg_q     <= 32'h0;
            av_readdata_q   <= 32'h0;
            monitor_ready_q <= 1'b1;
            monitor_error_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            pend_wr_q       <= pend_wr_d;
            jtag_addr_q     <= jtag_addr_d;
            jtag_wdata_q    <= jtag_wdata_d;
            last_grant_q    <= last_grant_d;
            cpu_wr_q        <= cpu_wr_d;
            mon_d_reg_q     <= mon_d_reg_d;
            av_readdata_q   <= av_readdata_d;
            monitor_ready_q <= monitor_ready_d;
            monitor_error_q <= monitor_error_d;
        end
    end

    // JTAG strobe capture, arbitration, next state and RAM port drive
    always_comb begin
        state_d         = state_q;
        pend_d          = pend_q;
        pend_wr_d       = pend_wr_q;
        jtag_addr_d     = jtag_addr_q;
        jtag_wdata_d    = jtag_wdata_q;
        last_grant_d    = last_grant_q;
        cpu_wr_d        = cpu_wr_q;
        mon_d_reg_d     = mon_d_reg_q;
        av_readdata_d   = av_readdata_q;
        monitor_ready_d = monitor_ready_q;
        monitor_error_d = monitor_error_q;
        ram_addr        = 8'h00;
        ram_wdata       = 32'h0;
        ram_be          = 4'h0;
        ram_we          = 1'b0;
        av_waitrequest  = cpu_req;

        // Only one JTAG op may be outstanding; a strobe while one is queued or
        // being serviced is lost, so flag it until the host re-arms with ocimem_a.
        if (any_strobe) begin
            if (pend_q) begin
                monitor_error_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                jtag_addr_d     = jdo[25:18];
                monitor_error_d = 1'b0;
                if (jdo[26]) begin
                    pend_d          = 1'b1;
                    pend_wr_d       = 1'b0;
                    monitor_ready_d = 1'b0;
                end
            end else if (take_action_ocimem_b) begin
                pend_d          = 1'b1;
                pend_wr_d       = 1'b1;
                jtag_wdata_d    = jdo[34:3];
                monitor_ready_d = 1'b0;
            end else begin
                pend_d          = 1'b1;
                pend_wr_d       = 1'b0;
                monitor_ready_d = 1'b0;
            end
        end

        case (state_q)
            S_IDLE: begin
                // On a tie the side that lost last time wins
                if (pend_q && (!cpu_req || last_grant_q == GRANT_CPU)) begin
                    state_d      = S_JTG_ACC;
                    last_grant_d = GRANT_JTAG;
                end else if (cpu_req) begin
                    state_d      = S_CPU_ACC;
                    last_grant_d = GRANT_CPU;
                    cpu_wr_d     = av_write;
                end
            end
            S_CPU_ACC: begin
                ram_addr  = av_address;
                ram_be    = av_byteenable;
                ram_wdata = av_writedata;
                if (cpu_wr_q) begin
                    // Non-debug CPU writes are acknowledged but never reach the RAM
                    ram_we         = av_debugaccess;
                    av_waitrequest = 1'b0;
                    state_d        = S_IDLE;
                end else begin
                    state_d = S_CPU_RD;
                end
            end
            S_CPU_RD: begin
                ram_addr      = av_address;
                ram_be        = av_byteenable;
                av_readdata_d = ram_rdata;
                state_d       = S_CPU_DONE;
            end
            S_CPU_DONE: begin
                av_waitrequest = 1'b0;
                state_d        = S_IDLE;
            end
            S_JTG_ACC: begin
                ram_addr = jtag_addr_q;
                ram_be   = 4'hF;
                if (pend_wr_q) begin
                    ram_we          = 1'b1;
                    ram_wdata       = jtag_wdata_q;
                    pend_d          = 1'b0;
                    monitor_ready_d = 1'b1;
                    jtag_addr_d     = jtag_addr_q + 8'd1;
                    state_d         = S_IDLE;
                end else begin
                    state_d = S_JTG_RD;
                end
            end
            S_JTG_RD: begin
                ram_addr        = jtag_addr_q;
                ram_be          = 4'hF;
                mon_d_reg_d     = ram_rdata;
                pend_d          = 1'b0;
                monitor_ready_d = 1'b1;
                jtag_addr_d     = jtag_addr_q + 8'd1;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_de2_115_qsys_cpu_ocimem_arbiter.sv
// tb/tb_de2_115_qsys_cpu_ocimem_arbiter.sv - directed self-checking bench for the OCI RAM arbiter

module tb_de2_115_qsys_cpu_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
    logic [7:0]  av_address;
    logic        av_read, av_write, av_debugaccess;
    logic [31:0] av_writedata;
    logic [3:0]  av_byteenable;
    logic [31:0] av_readdata;
    logic        av_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;
    logic [31:0] mem [256];

    int n_cmp = 0;
    int n_err = 0;

    de2_115_qsys_cpu_ocimem_arbiter dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_debugaccess          (av_debugaccess),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_we                  (ram_we),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // 256 x 32 RAM with byte-enabled write and one-cycle registered read
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (ram_we) begin
            for (int i = 0; i < 4; i++)
                if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
        logic [37:0] v;
        v        = '0;
        v[25:18] = a;
        v[26]    = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        logic [37:0] v;
        v       = '0;
        v[34:3] = d;
        return v;
    endfunction

    // kind: 0 = ocimem_a, 1 = ocimem_b, 2 = no_action read; returns in cycle 1
    task automatic jtag(input int kind, input logic [37:0] v);
        tick();
        jdo                     = v;
        take_action_ocimem_a    = (kind == 0);
        take_action_ocimem_b    = (kind == 1);
        take_no_action_ocimem_a = (kind == 2);
        tick();
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 20; i++) begin
            sample();
            if (monitor_ready) break;
            tick();
        end
        check_eq(tag, monitor_ready, 1'b1);
    endtask

    task automatic cpu_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic da);
        tick();
        av_address = a; av_writedata = d; av_byteenable = be; av_debugaccess = da; av_write = 1'b1;
        sample();
        check_eq({tag, "_wait_c0"}, av_waitrequest, 1'b1);
        tick();
        sample();
        check_eq({tag, "_wait_c1"}, av_waitrequest, 1'b0);
        check_eq({tag, "_we_c1"}, ram_we, da);
        if (da) begin
            check_eq({tag, "_addr"}, ram_addr, a);
            check_eq({tag, "_be"}, ram_be, be);
            check_eq({tag, "_wdata"}, ram_wdata, d);
        end
        tick();
        av_write = 1'b0; av_debugaccess = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
        int lat;
        lat = 99;
        tick();
        av_address = a; av_read = 1'b1;
        for (int n = 0; n < 20; n++) begin
            sample();
            if (!av_waitrequest) begin lat = n; break; end
            tick();
        end
        check_eq({tag, "_lat"}, lat, 3);
        check_eq({tag, "_data"}, av_readdata, exp);
        tick();
        av_read = 1'b0;
    endtask

    // Called in cycle 1 after a JTAG strobe: raises a CPU read and records
    // the cycle of CPU completion and of JTAG completion
    task automatic race(input logic [7:0] a, output int cpu_cyc, output int jtag_cyc,
                        output logic [31:0] rd);
        cpu_cyc = 0; jtag_cyc = 0; rd = 32'h0;
        av_address = a; av_read = 1'b1;
        for (int c = 1; c < 30; c++) begin
            sample();
            if (cpu_cyc == 0 && av_read && !av_waitrequest) begin
                cpu_cyc = c; rd = av_readdata;
            end
            if (jtag_cyc == 0 && monitor_ready) jtag_cyc = c;
            tick();
            if (cpu_cyc != 0) av_read = 1'b0;
            if (cpu_cyc != 0 && jtag_cyc != 0) break;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cc, jc;
        logic [31:0] rd;
        int we_seen;

        reset_n = 1'b0; jdo = '0;
        take_action_ocimem_a = 0; take_action_ocimem_b = 0; take_no_action_ocimem_a = 0;
        av_address = 0; av_read = 0; av_write = 0; av_debugaccess = 0;
        av_writedata = 0; av_byteenable = 0;
        pre_we = 0; pre_addr = 0; pre_data = 0;

        preload(8'h11, 32'hCAFE0011);
        preload(8'hFF, 32'h12345678);
        preload(8'h00, 32'hA5A50000);
        preload(8'h20, 32'hAABBCCDD);
        preload(8'h02, 32'h22222222);
        preload(8'h03, 32'h33333333);
        preload(8'h50, 32'h55555555);
        tick();
        reset_n = 1'b1;

        sample();
        check_eq("rst_ready", monitor_ready, 1'b1);
        check_eq("rst_error", monitor_error, 1'b0);
        check_eq("rst_mondreg", MonDReg, 32'h0);
        check_eq("rst_readdata", av_readdata, 32'h0);
        check_eq("rst_we", ram_we, 1'b0);
        check_eq("rst_wait", av_waitrequest, 1'b0);

        // JTAG write at 0x10 and its timing
        jtag(0, jdo_a(8'h10, 1'b0));
        jtag(1, jdo_b(32'hDEADBEEF));
        sample();
        check_eq("jw_ready_c1", monitor_ready, 1'b0);
        check_eq("jw_we_c1", ram_we, 1'b0);
        tick(); sample();
        check_eq("jw_we_c2", ram_we, 1'b1);
        check_eq("jw_addr_c2", ram_addr, 8'h10);
        check_eq("jw_wdata_c2", ram_wdata, 32'hDEADBEEF);
        check_eq("jw_be_c2", ram_be, 4'hF);
        tick(); sample();
        check_eq("jw_ready_c3", monitor_ready, 1'b1);
        check_eq("jw_we_c3", ram_we, 1'b0);

        // Address auto-incremented to 0x11
        jtag(2, '0);
        tick(); sample();
        check_eq("jr11_addr_c2", ram_addr, 8'h11);
        tick(); tick(); sample();
        check_eq("jr11_mondreg_c4", MonDReg, 32'hCAFE0011);

        // Read at 0xFF, then wrap to 0x00
        jtag(0, jdo_a(8'hFF, 1'b0));
        jtag(2, '0);
        tick(); sample();
        check_eq("jrff_addr_c2", ram_addr, 8'hFF);
        tick(); sample();
        check_eq("jrff_ready_c3", monitor_ready, 1'b0);
        tick(); sample();
        check_eq("jrff_mondreg_c4", MonDReg, 32'h12345678);
        check_eq("jrff_ready_c4", monitor_ready, 1'b1);
        jtag(2, '0);
        tick(); sample();
        check_eq("jwrap_addr_c2", ram_addr, 8'h00);
        tick(); tick(); sample();
        check_eq("jwrap_mondreg_c4", MonDReg, 32'hA5A50000);

        // CPU writes with and without debugaccess, then CPU reads
        cpu_write("cw_nodbg", 8'h20, 32'h11111111, 4'hF, 1'b0);
        cpu_write("cw_dbg", 8'h20, 32'h11223344, 4'b0011, 1'b1);
        cpu_read("cr_20", 8'h20, 32'hAABB3344);
        cpu_read("cr_10", 8'h10, 32'hDEADBEEF);

        // Arbitration after reset: JTAG wins the first tie
        tick(); reset_n = 1'b0; tick(); reset_n = 1'b1;
        jtag(2, '0);
        race(8'h10, cc, jc, rd);
        check_eq("tie1_jtag_cyc", jc, 4);
        check_eq("tie1_cpu_cyc", cc, 7);
        check_eq("tie1_cpu_data", rd, 32'hDEADBEEF);
        check_eq("tie1_mondreg", MonDReg, 32'hA5A50000);

        // Lone JTAG write at 0x01 leaves JTAG as last granted; next tie goes to CPU
        jtag(1, jdo_b(32'h0BADF00D));
        wait_ready("lone_write_ready");
        jtag(2, '0);
        race(8'h01, cc, jc, rd);
        check_eq("tie2_cpu_cyc", cc, 4);
        check_eq("tie2_jtag_cyc", jc, 8);
        check_eq("tie2_cpu_data", rd, 32'h0BADF00D);
        check_eq("tie2_mondreg", MonDReg, 32'h22222222);

        // Second strobe while first pending is dropped and flagged
        jtag(2, '0);
        jdo = jdo_b(32'hFFFFFFFF); take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        we_seen = 0;
        sample();
        check_eq("drop_error_c2", monitor_error, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (ram_we) we_seen++;
            tick(); sample();
        end
        check_eq("drop_no_we", we_seen, 0);
        check_eq("drop_mondreg", MonDReg, 32'h33333333);
        check_eq("drop_error_sticky", monitor_error, 1'b1);
        jtag(0, jdo_a(8'h50, 1'b0));
        sample();
        check_eq("error_cleared", monitor_error, 1'b0);

        // Reset asserted during JTG_RD
        jtag(2, '0);
        tick(); tick(); sample();
        check_eq("rrd_ready_c3", monitor_ready, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rrd_ready", monitor_ready, 1'b1);
        check_eq("rrd_mondreg", MonDReg, 32'h0);
        check_eq("rrd_we", ram_we, 1'b0);
        check_eq("rrd_wait", av_waitrequest, 1'b0);
        we_seen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ram_we) we_seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            if (ram_we) we_seen++;
            tick();
        end
        check_eq("rrd_no_we_after", we_seen, 0);
        jtag(2, '0);
        tick(); sample();
        check_eq("post_rst_addr_c2", ram_addr, 8'h00);
        tick(); tick(); sample();
        check_eq("post_rst_mondreg_c4", MonDReg, 32'hA5A50000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
